// File: rtl/stuff_tx_pkg.sv
// ============================================================================
// Module : stuff_tx_pkg
// Brief  : Shared state encoding and frame marker for the stuffing transmitter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package stuff_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MARK1  = 3'd1,
        MARK2  = 3'd2,
        GUARD  = 3'd3,
        DATA   = 3'd4,
        STUFF  = 3'd5,
        PARITY = 3'd6
    } state_t;

    // Start-of-frame pattern; bit stuffing guarantees it never recurs in a frame.
    localparam logic [1:0] MARKER = 2'b11;

endpackage : stuff_tx_pkg

`default_nettype wire

// File: rtl/stuff_tx.sv
// ============================================================================
// Module : stuff_tx
// Brief  : Serial frame transmitter: marker 1,1,0 then MSB-first payload with a
//          0 stuffed after every 1. Optional even-parity bit via STUFF_TX_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stuff_tx
    import stuff_tx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              w,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              w_q,     w_d;
    logic              done_q,  done_d;
    logic              emit_bit;
    logic              finish;
`ifdef STUFF_TX_PARITY_EN
    logic              par_q,      par_d;
    logic              par_sent_q, par_sent_d;
`endif

    // w_d is the line level for the cycle spent in state_d, so w stays registered.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        w_d      = 1'b0;
        done_d   = 1'b0;
        emit_bit = 1'b0;
        finish   = 1'b0;
`ifdef STUFF_TX_PARITY_EN
        par_d      = par_q;
        par_sent_d = par_sent_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = MARK1;
                    w_d     = MARKER[1];
                    shift_d = in_data;
                    cnt_d   = CNT_W'(DATA_W);
`ifdef STUFF_TX_PARITY_EN
                    par_d      = ^in_data;
                    par_sent_d = 1'b0;
`endif
                end
            end
            MARK1: begin
                state_d = MARK2;
                w_d     = MARKER[0];
            end
            MARK2: begin
                state_d = GUARD;
                w_d     = 1'b0;
            end
            GUARD: begin
                emit_bit = 1'b1;
            end
            DATA: begin
                if (w_q) begin
                    state_d = STUFF;
                    w_d     = 1'b0;
                end else if (cnt_q != '0) begin
                    emit_bit = 1'b1;
                end else begin
                    finish = 1'b1;
                end
            end
            STUFF: begin
                if (cnt_q != '0) begin
                    emit_bit = 1'b1;
                end else begin
                    finish = 1'b1;
                end
            end
`ifdef STUFF_TX_PARITY_EN
            PARITY: begin
                if (w_q) begin
                    state_d = STUFF;
                    w_d     = 1'b0;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (emit_bit) begin
            state_d = DATA;
            w_d     = shift_q[DATA_W-1];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CNT_W'(1);
        end

        if (finish) begin
`ifdef STUFF_TX_PARITY_EN
            // Payload exhausted: send parity once, then close the frame.
            if (!par_sent_q) begin
                state_d    = PARITY;
                w_d        = par_q;
                par_sent_d = 1'b1;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            w_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            done_q  <= done_d;
        end
    end

`ifdef STUFF_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q      <= 1'b0;
            par_sent_q <= 1'b0;
        end else begin
            par_q      <= par_d;
            par_sent_q <= par_sent_d;
        end
    end
`endif

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign w        = w_q;
    assign done     = done_q;

endmodule : stuff_tx

`default_nettype wire

// File: tb/tb_stuff_tx.sv
// ============================================================================
// Module : tb_stuff_tx
// Brief  : Scoreboard bench for stuff_tx; honours STUFF_TX_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stuff_tx;

    localparam int DATA_W = 8;

    // Expected per-cycle observation: {w, busy, done, in_ready}
    typedef logic [3:0] exp_t;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              w;
    logic              busy;
    logic              done;

    exp_t exp_q[$];
    exp_t mon_exp;
    exp_t mon_act;
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b1;
    logic [DATA_W-1:0] rnd_d;
    bit   rnd_keep;

    stuff_tx #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .w        (w),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endfunction

    // Reference frame: marker, MSB-first bits each 1 followed by a 0, optional parity, then done.
    function automatic void push_frame(input logic [DATA_W-1:0] d);
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0100);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            exp_q.push_back({d[i], 3'b100});
            if (d[i]) exp_q.push_back(4'b0100);
        end
`ifdef STUFF_TX_PARITY_EN
        begin
            int ones = 0;
            for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
            exp_q.push_back({ones % 2 == 1, 3'b100});
            if (ones % 2 == 1) exp_q.push_back(4'b0100);
        end
`endif
        exp_q.push_back(4'b0011);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            mon_act = {w, busy, done, in_ready};
            if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
            else                  mon_exp = 4'b0001;
            check("line{w,busy,done,rdy}", 32'(mon_act), 32'(mon_exp));
        end
    end

    task automatic send(input logic [DATA_W-1:0] d, input bit keep);
        bit ok = 1'b0;
        bit rdy;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (i > 0) @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy && !rst) begin
                push_frame(d);
                ok = 1'b1;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        if (!keep) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a pending offer: nothing may start.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        #2 check("reset_hold", 32'({w, busy, done, in_ready}), 32'h1);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1 check("reset_release", 32'({w, busy, done, in_ready}), 32'h1);
        repeat (2) @(negedge clk);

        send(8'h00, 1'b0); wait_idle();
        send(8'hA5, 1'b0); wait_idle();
        send(8'hFF, 1'b0); wait_idle();

        // Back-to-back with valid held, then abort the second frame mid-payload.
        send(8'h80, 1'b1);
        send(8'h01, 1'b0);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        #1 check("abort_rst", 32'({w, busy, done, in_ready}), 32'h1);
        in_valid = 1'b1;
        in_data  = DATA_W'($urandom);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1 check("abort_release", 32'({w, busy, done, in_ready}), 32'h1);
        repeat (2) @(negedge clk);

        send(8'h01, 1'b0); wait_idle();

        for (int k = 0; k < 40; k++) begin
            rnd_d    = DATA_W'($urandom);
            rnd_keep = (k != 39) && ($urandom_range(0, 1) == 1);
            send(rnd_d, rnd_keep);
            if (!rnd_keep && $urandom_range(0, 1) == 1)
                repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_stuff_tx

`default_nettype wire
